branch_predictor: RTL and testbench

- Fetch-side branch predictor with a direct-mapped BTB (branch target buffer) and a 2-bit saturating counter per entry.
- Fetch queries it with the current PC. It returns a taken prediction and a predicted target.
- The execute stage feeds back the resolved outcome produced by the branch control unit: taken flag, target and instruction kind.
- From that feedback the block trains the table and flags mispredicts so the pipeline can flush and redirect.

---
 rtl/branch_predictor.sv | 174 +++++++++++++++++
 tb/tb_branch_predictor.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating counter
// per entry, trained from resolved execute-stage outcomes; flags mispredicts.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] f_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);

  localparam int DEPTH    = 1 << IDX_BITS;
  localparam int TAG_BITS = XLEN - IDX_BITS - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(32'd4);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Saturating 2-bit counter step: never wraps between 11 and 00.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    logic [1:0] nxt;
    case ({up, ctr})
      3'b1_00: nxt = 2'b01;
      3'b1_01: nxt = 2'b10;
      3'b1_10: nxt = 2'b11;
      3'b1_11: nxt = 2'b11;
      3'b0_00: nxt = 2'b00;
      3'b0_01: nxt = 2'b00;
      3'b0_10: nxt = 2'b01;
      3'b0_11: nxt = 2'b10;
      default: nxt = 2'b01;
    endcase
    return nxt;
  endfunction

  logic                valid_r  [DEPTH];
  logic                jump_r   [DEPTH];
  logic [TAG_BITS-1:0] tag_r    [DEPTH];
  logic [XLEN-1:0]     target_r [DEPTH];
  logic [1:0]          ctr_r    [DEPTH];
  logic [31:0]         br_count_r;
  logic [31:0]         mp_count_r;

  logic [IDX_BITS-1:0] f_idx_s;
  logic [TAG_BITS-1:0] f_tag_s;
  logic                f_hit_s;
  logic                pred_taken_s;
  logic [XLEN-1:0]     pred_target_s;
  logic [IDX_BITS-1:0] e_idx_s;
  logic [TAG_BITS-1:0] e_tag_s;
  logic                e_hit_s;
  logic                e_ctl_s;
  logic                mispredict_s;
  logic [XLEN-1:0]     redirect_s;

  assign f_idx_s = f_pc[IDX_BITS+1:2];
  assign f_tag_s = f_pc[XLEN-1:IDX_BITS+2];
  assign e_idx_s = ex_pc[IDX_BITS+1:2];
  assign e_tag_s = ex_pc[XLEN-1:IDX_BITS+2];
  assign e_ctl_s = ex_is_branch | ex_is_jump;

  // Prediction lookup from the registered table; no bypass of same-cycle training.
  always_comb begin
    f_hit_s       = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
    pred_taken_s  = 1'b0;
    pred_target_s = f_pc + PC_STEP;
    if (f_hit_s && (jump_r[f_idx_s] || ctr_r[f_idx_s][1])) begin
      pred_taken_s  = 1'b1;
      pred_target_s = target_r[f_idx_s];
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = f_pc + PC_STEP;
    end
  end

  // Mispredict detection and correct next-PC for the resolved instruction.
  always_comb begin
    e_hit_s      = valid_r[e_idx_s] && (tag_r[e_idx_s] == e_tag_s);
    mispredict_s = 1'b0;
    redirect_s   = ex_pc + PC_STEP;
    if (!ex_valid) begin
      mispredict_s = 1'b0;
    end else if (e_ctl_s) begin
      mispredict_s = (ex_taken != ex_pred_taken) ||
                     (ex_taken && (ex_target != ex_pred_target));
    end else begin
      mispredict_s = ex_pred_taken;
    end
    if (ex_taken && e_ctl_s) begin
      redirect_s = ex_target;
    end else begin
      redirect_s = ex_pc + PC_STEP;
    end
  end

  assign pred_taken  = pred_taken_s;
  assign pred_target = pred_target_s;
  assign mispredict  = mispredict_s;
  assign redirect_pc = redirect_s;
  assign br_count    = br_count_r;
  assign mp_count    = mp_count_r;

  // Table training; a set jump bit takes priority when both kind flags are set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i]  <= 1'b0;
        jump_r[i]   <= 1'b0;
        tag_r[i]    <= {TAG_BITS{1'b0}};
        target_r[i] <= {XLEN{1'b0}};
        ctr_r[i]    <= 2'b01;
      end
    end else if (ex_valid) begin
      case ({ex_is_jump, ex_is_branch})
        2'b10, 2'b11: begin
          valid_r[e_idx_s]  <= 1'b1;
          jump_r[e_idx_s]   <= 1'b1;
          tag_r[e_idx_s]    <= e_tag_s;
          target_r[e_idx_s] <= ex_target;
          ctr_r[e_idx_s]    <= 2'b11;
        end
        2'b01: begin
          if (e_hit_s) begin
            ctr_r[e_idx_s] <= ctr_step(ctr_r[e_idx_s], ex_taken);
            if (ex_taken) begin
              target_r[e_idx_s] <= ex_target;
            end
          end else if (ex_taken) begin
            valid_r[e_idx_s]  <= 1'b1;
            jump_r[e_idx_s]   <= 1'b0;
            tag_r[e_idx_s]    <= e_tag_s;
            target_r[e_idx_s] <= ex_target;
            ctr_r[e_idx_s]    <= 2'b10;
          end
        end
        2'b00: begin
          if (e_hit_s) begin
            valid_r[e_idx_s] <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Resolved control-flow and mispredict counters, both saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_r <= 32'd0;
      mp_count_r <= 32'd0;
    end else begin
      if (ex_valid && e_ctl_s && (br_count_r != CNT_MAX)) begin
        br_count_r <= br_count_r + 32'd1;
      end
      if (mispredict_s && (mp_count_r != CNT_MAX)) begin
        mp_count_r <= mp_count_r + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: the driver pushes hand-computed expectations into a scoreboard
// queue tagged with their cycle; a negedge monitor pops and compares them.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_count;
  logic [31:0] mp_count;

  branch_predictor #(.IDX_BITS(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mon_act;
  int          cyc_count = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  function automatic logic [31:0] actual_of(input int kind);
    case (kind)
      0: return {31'd0, pred_taken};
      1: return pred_target;
      2: return {31'd0, mispredict};
      3: return redirect_pc;
      4: return br_count;
      default: return mp_count;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_count) begin
      mon_e   = sb.pop_front();
      mon_act = actual_of(mon_e.kind);
      tests++;
      if (mon_e.cyc != cyc_count || mon_act !== mon_e.val) begin
        fails++;
        $display("FAIL %s (kind %0d): got 0x%08h, expected 0x%08h", mon_e.name, mon_e.kind, mon_act, mon_e.val);
      end
    end
  end

  task automatic push(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = name; e.kind = kind; e.val = val; e.cyc = cyc_count;
    sb.push_back(e);
  endtask

  task automatic exp_pred(input string name, input logic tk, input logic [31:0] tgt);
    push({name, ".taken"}, 0, {31'd0, tk});
    push({name, ".target"}, 1, tgt);
  endtask

  task automatic exp_mp(input string name, input logic mp, input logic [31:0] rd);
    push({name, ".mispredict"}, 2, {31'd0, mp});
    push({name, ".redirect"}, 3, rd);
  endtask

  task automatic exp_cnt(input string name, input logic [31:0] br, input logic [31:0] mp);
    push({name, ".br_count"}, 4, br);
    push({name, ".mp_count"}, 5, mp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                    input logic tk, input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_is_branch = br; ex_is_jump = jmp;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic idle();
    ex(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; f_pc = 32'h100; idle();
    tick();
    tests++;
    if (pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL direct rst.taken: got %0b, expected 0", pred_taken);
    end
    tests++;
    if (pred_target !== 32'h104) begin
      fails++;
      $display("FAIL direct rst.target: got 0x%08h, expected 0x00000104", pred_target);
    end
    exp_pred("rst", 1'b0, 32'h104); exp_cnt("rst", 32'd0, 32'd0); exp_mp("rst", 1'b0, 32'h4);
    tick(); rst = 1'b0;

    // First taken branch at 0x100: mispredict, no same-cycle bypass
    ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    exp_mp("br_first", 1'b1, 32'h80); exp_pred("br_first_nobypass", 1'b0, 32'h104);
    tick(); idle();
    exp_pred("br_learn", 1'b1, 32'h80); exp_cnt("cnt1", 32'd1, 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
      exp_mp("tk_again", 1'b0, 32'h80);
      tick();
    end
    ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    exp_mp("nt1", 1'b1, 32'h104); exp_cnt("cnt4", 32'd4, 32'd1);
    tick(); idle();
    exp_pred("ctr10", 1'b1, 32'h80); exp_cnt("cnt5", 32'd5, 32'd2);
    tick();
    ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
    exp_mp("nt2", 1'b1, 32'h104);
    tick(); idle();
    exp_pred("ctr01", 1'b0, 32'h104); exp_cnt("cnt6", 32'd6, 32'd3);
    tick();
    for (int i = 0; i < 2; i++) begin
      ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'h0);
      exp_mp("nt_low", 1'b0, 32'h104);
      tick();
    end
    ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    exp_mp("tk_from00", 1'b1, 32'h80);
    tick(); idle();
    exp_pred("no_wrap_low", 1'b0, 32'h104);
    tick();
    ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    tick(); idle();
    exp_pred("ctr10b", 1'b1, 32'h80); exp_cnt("cnt10", 32'd10, 32'd5);
    tick();

    // Jumps at 0x200 (same index as 0x100)
    f_pc = 32'h200;
    ex(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
    exp_mp("jal_mp", 1'b1, 32'h400);
    tick(); idle();
    exp_pred("jal_learn", 1'b1, 32'h400); exp_cnt("cnt11", 32'd11, 32'd6);
    tick();
    f_pc = 32'h100;
    exp_pred("jal_evicts_100", 1'b0, 32'h104);
    tick();
    f_pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      ex(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h400, 1'b1, 32'h400);
      exp_mp("br_on_jmp", 1'b1, 32'h204);
      tick();
    end
    idle();
    exp_pred("jmp_sticky", 1'b1, 32'h400); exp_cnt("cnt13", 32'd13, 32'd8);
    tick();
    ex(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h400);
    exp_mp("jal_hit", 1'b0, 32'h400);
    tick();
    ex(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h300);
    exp_mp("jal_bad_tgt", 1'b1, 32'h400);
    tick(); idle();
    exp_cnt("cnt15", 32'd15, 32'd9);
    tick();

    // Aliasing 0x100 / 0x140 on index 0, then stale-entry purge
    ex(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h0);
    exp_mp("alias_a", 1'b1, 32'h80);
    tick();
    ex(1'b1, 32'h140, 1'b1, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    exp_mp("alias_b", 1'b1, 32'h500);
    tick(); idle(); f_pc = 32'h100;
    exp_pred("alias_evict", 1'b0, 32'h104);
    tick(); f_pc = 32'h140;
    exp_pred("alias_hit", 1'b1, 32'h500); exp_cnt("cnt17", 32'd17, 32'd11);
    tick();
    ex(1'b1, 32'h140, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
    exp_mp("purge_mp", 1'b1, 32'h144);
    tick(); idle();
    exp_pred("purged", 1'b0, 32'h144); exp_cnt("cnt17b", 32'd17, 32'd12);
    tick();
    ex(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 32'h999, 1'b0, 32'h0);
    exp_mp("nonbr_ok", 1'b0, 32'h44);
    tick();

    // Same-cycle fetch and training of 0x300
    f_pc = 32'h300;
    ex(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0, 32'h0);
    exp_pred("same_cycle", 1'b0, 32'h304); exp_mp("same_cycle", 1'b1, 32'h600);
    tick(); idle();
    exp_pred("next_cycle", 1'b1, 32'h600); exp_cnt("cnt18", 32'd18, 32'd13);
    tick();

    // Branch and jump both set: trained as a jump
    f_pc = 32'h380;
    ex(1'b1, 32'h380, 1'b1, 1'b1, 1'b0, 32'h700, 1'b0, 32'h0);
    exp_mp("illegal", 1'b0, 32'h384);
    tick(); idle();
    exp_pred("illegal_as_jump", 1'b1, 32'h700); exp_cnt("cnt19", 32'd19, 32'd13);
    tick();

    f_pc = 32'hFFFF_FFFC;
    exp_pred("pc_wrap", 1'b0, 32'h0);
    tick();

    // Counter saturation from a preloaded near-max value
    force dut.br_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.br_count_r;
    ex(1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    exp_cnt("sat_reach", 32'hFFFF_FFFF, 32'd13);
    tick(); idle();
    tests++;
    if (br_count !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL direct sat_hold.br_count: got 0x%08h, expected 0xffffffff", br_count);
    end
    exp_cnt("sat_hold", 32'hFFFF_FFFF, 32'd13);
    tick();

    // Mid-run reset takes effect immediately
    f_pc = 32'h380; rst = 1'b1;
    #1;
    tests++;
    if (pred_taken !== 1'b0) begin
      fails++;
      $display("FAIL direct rst_mid.taken: got %0b, expected 0", pred_taken);
    end
    tests++;
    if (br_count !== 32'd0) begin
      fails++;
      $display("FAIL direct rst_mid.br_count: got 0x%08h, expected 0x00000000", br_count);
    end
    exp_pred("rst_mid", 1'b0, 32'h384); exp_cnt("rst_mid", 32'd0, 32'd0);
    tick(); rst = 1'b0; f_pc = 32'h100;
    exp_pred("rst_after", 1'b0, 32'h104);
    tick();

    repeat (3) tick();
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: expectation never checked, expected 0x%08h", mon_e.name, mon_e.val);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
